// File: rtl/regbank_pkg.sv
// Shared types and constants for the register bank: op-code encoding,
// the largest supported register count and the index-width helper.
package regbank_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LD_DB   = 3'd1,
    OP_LD_ALU  = 3'd2,
    OP_INC     = 3'd3,
    OP_DEC     = 3'd4,
    OP_XFER    = 3'd5,
    OP_CLR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } regbank_op_e;

  localparam int REGBANK_MAX_REGS = 8;

  // Index ports are never narrower than one bit, even for a single register.
  function automatic int regbank_idx_width(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regbank_nz_flags.sv
// Negative/zero status flags, registered from the value written to the bank.
// A load port lets a saved context overwrite the flags in one edge.
module regbank_nz_flags #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             load_en_i,
  input  logic             load_n_i,
  input  logic             load_z_i,
  output logic             flag_n_o,
  output logic             flag_z_o
);

  logic flag_n_d, flag_z_d;
  logic flag_n_q, flag_z_q;

  // Next-state: context load has priority over a normal write; otherwise hold.
  always_comb begin
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    if (load_en_i) begin
      flag_n_d = load_n_i;
      flag_z_d = load_z_i;
    end else if (wr_en_i) begin
      flag_n_d = wr_data_i[WIDTH-1];
      flag_z_d = (wr_data_i == {WIDTH{1'b0}});
    end else begin
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
    end
  end

  // Flag state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_n_o = flag_n_q;
  assign flag_z_o = flag_z_q;

endmodule

// File: rtl/register_bank.sv
// Small CPU-style register bank (index 0 is the accumulator) with single-cycle ops.
// Optional context shadow (ctx_save/ctx_restore) is built when REGBANK_SHADOW_EN is defined.
module register_bank
  import regbank_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  NUM_REGS = 3,
  localparam int IDXW     = regbank_idx_width(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [IDXW-1:0]  op_dst,
  input  logic [IDXW-1:0]  op_src,
  input  logic [WIDTH-1:0] db_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [IDXW-1:0]  rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_out,
  output logic             wb_valid,
  output logic             flag_n,
  output logic             flag_z,
  output logic             err_op
`ifdef REGBANK_SHADOW_EN
  ,
  input  logic             ctx_save,
  input  logic             ctx_restore
`endif
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             wb_valid_q, wb_valid_d;
  logic             err_op_q, err_op_d;

  regbank_op_e      op_e_s;
  logic [WIDTH-1:0] src_val_s, dst_val_s, wr_val_s, rd_val_s;
  logic             dst_ok_s, src_ok_s, legal_s, accept_s, wr_en_s;
  logic             save_s, restore_s;
  logic [WIDTH-1:0] shadow_s [NUM_REGS];
  logic             shadow_n_s, shadow_z_s;

`ifdef REGBANK_SHADOW_EN
  logic [WIDTH-1:0] shadow_q [NUM_REGS];
  logic             shadow_n_q, shadow_z_q;

  assign save_s     = ctx_save;
  assign restore_s  = ctx_restore;
  assign shadow_s   = shadow_q;
  assign shadow_n_s = shadow_n_q;
  assign shadow_z_s = shadow_z_q;

  // Shadow context: captures pre-edge registers and flags, so save+restore swaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= {WIDTH{1'b0}};
      shadow_n_q <= 1'b0;
      shadow_z_q <= 1'b0;
    end else if (save_s) begin
      shadow_q   <= regs_q;
      shadow_n_q <= flag_n;
      shadow_z_q <= flag_z;
    end else begin
      shadow_q   <= shadow_q;
      shadow_n_q <= shadow_n_q;
      shadow_z_q <= shadow_z_q;
    end
  end
`else
  assign save_s     = 1'b0;
  assign restore_s  = 1'b0;
  assign shadow_n_s = 1'b0;
  assign shadow_z_s = 1'b0;
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) shadow_s[i] = {WIDTH{1'b0}};
  end
`endif

  assign op_e_s   = regbank_op_e'(op_code);
  assign dst_ok_s = (32'(op_dst) < NUM_REGS);
  assign src_ok_s = (32'(op_src) < NUM_REGS);

  // Operand fetch and result selection; all reads use pre-edge register values.
  always_comb begin
    src_val_s = {WIDTH{1'b0}};
    dst_val_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      src_val_s = (op_src == IDXW'(i)) ? regs_q[i] : src_val_s;
      dst_val_s = (op_dst == IDXW'(i)) ? regs_q[i] : dst_val_s;
    end
    case (op_e_s)
      OP_LD_DB:  wr_val_s = db_in;
      OP_LD_ALU: wr_val_s = alu_in;
      OP_INC:    wr_val_s = dst_val_s + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC:    wr_val_s = dst_val_s - {{(WIDTH-1){1'b0}}, 1'b1};
      OP_XFER:   wr_val_s = src_val_s;
      OP_CLR:    wr_val_s = {WIDTH{1'b0}};
      default:   wr_val_s = dst_val_s;
    endcase
  end

  // A restore in the same cycle swallows the op entirely, including its pulses.
  assign legal_s  = (op_e_s != OP_ILLEGAL) && dst_ok_s && ((op_e_s != OP_XFER) || src_ok_s);
  assign accept_s = op_valid && !restore_s && (op_e_s != OP_NOP);
  assign wr_en_s  = accept_s && legal_s;

  // Register-file next state and completion/error pulses.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = restore_s ? shadow_s[i]
                : ((wr_en_s && (op_dst == IDXW'(i))) ? wr_val_s : regs_q[i]);
    end
    wb_valid_d = wr_en_s;
    err_op_d   = accept_s && !legal_s;
  end

  // Register file and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= {WIDTH{1'b0}};
      wb_valid_q <= 1'b0;
      err_op_q   <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      err_op_q   <= err_op_d;
    end
  end

  regbank_nz_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en_s),
    .wr_data_i(wr_val_s),
    .load_en_i(restore_s),
    .load_n_i (shadow_n_s),
    .load_z_i (shadow_z_s),
    .flag_n_o (flag_n),
    .flag_z_o (flag_z)
  );

  // Read port: out-of-range selects return zero.
  always_comb begin
    rd_val_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val_s = (rd_sel == IDXW'(i)) ? regs_q[i] : rd_val_s;
    end
  end

  assign rd_data  = rd_val_s;
  assign alu_out  = regs_q[0];
  assign wb_valid = wb_valid_q;
  assign err_op   = err_op_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank (WIDTH=8, NUM_REGS=3) with an arithmetic reference
// model compared every cycle; shadow tests are included when REGBANK_SHADOW_EN is defined.
module tb_register_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic [1:0] op_dst = 2'd0;
  logic [1:0] op_src = 2'd0;
  logic [7:0] db_in = 8'd0;
  logic [7:0] alu_in = 8'd0;
  logic [1:0] rd_sel = 2'd0;
  logic       sv = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] rd_data, alu_out;
  logic       wb_valid, flag_n, flag_z, err_op;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Reference model state
  int m_regs [3];
  int m_sh   [3];
  int m_n, m_z, m_wb, m_err, m_sh_n, m_sh_z;

  register_bank #(.WIDTH(8), .NUM_REGS(3)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_dst(op_dst), .op_src(op_src), .db_in(db_in), .alu_in(alu_in),
    .rd_sel(rd_sel), .rd_data(rd_data), .alu_out(alu_out),
    .wb_valid(wb_valid), .flag_n(flag_n), .flag_z(flag_z), .err_op(err_op)
`ifdef REGBANK_SHADOW_EN
    , .ctx_save(sv), .ctx_restore(rs)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge();
    int old [3];
    int old_n, old_z, val;
    old = m_regs; old_n = m_n; old_z = m_z;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_regs[i] = 0; m_sh[i] = 0; end
      m_n = 0; m_z = 0; m_wb = 0; m_err = 0; m_sh_n = 0; m_sh_z = 0;
    end else begin
      if (rs) begin
        m_regs = m_sh; m_n = m_sh_n; m_z = m_sh_z;
        m_wb = 0; m_err = 0;
      end else if (!op_valid || op_code == 3'd0) begin
        m_wb = 0; m_err = 0;
      end else if (op_code == 3'd7 || op_dst >= 2'd3 || (op_code == 3'd5 && op_src >= 2'd3)) begin
        m_wb = 0; m_err = 1;
      end else begin
        case (op_code)
          3'd1: val = db_in;
          3'd2: val = alu_in;
          3'd3: val = (old[op_dst] + 1) % 256;
          3'd4: val = (old[op_dst] + 255) % 256;
          3'd5: val = old[op_src];
          default: val = 0;
        endcase
        m_regs[op_dst] = val;
        m_n = (val >= 128) ? 1 : 0;
        m_z = (val == 0) ? 1 : 0;
        m_wb = 1; m_err = 0;
      end
      if (sv) begin m_sh = old; m_sh_n = old_n; m_sh_z = old_z; end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] c, input logic [1:0] d,
                      input logic [1:0] s, input logic [7:0] db, input logic [7:0] alu,
                      input logic save, input logic rest);
    reset = r; op_valid = v; op_code = c; op_dst = d; op_src = s;
    db_in = db; alu_in = alu; sv = save; rs = rest;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("alu_out", int'(alu_out), m_regs[0]);
      check("rd_data", int'(rd_data), (rd_sel < 2'd3) ? m_regs[rd_sel] : 0);
      check("wb_valid", int'(wb_valid), m_wb);
      check("err_op", int'(err_op), m_err);
      check("flag_n", int'(flag_n), m_n);
      check("flag_z", int'(flag_z), m_z);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin m_regs[i] = 0; m_sh[i] = 0; end
    m_n = 0; m_z = 0; m_wb = 0; m_err = 0; m_sh_n = 0; m_sh_z = 0;

    // Reset with a simultaneous load that must be discarded
    step(1'b1, 1'b1, 3'd1, 2'd0, 2'd0, 8'h55, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("pin_rst_reg0", int'(alu_out), 0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_rst_nowb", int'(wb_valid), 0);

    // Load negative value into reg1
    step(1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 8'h80, 8'h00, 1'b0, 1'b0);
    rd_sel = 2'd1; #1;
    check("pin_ld_reg1", int'(rd_data), 8'h80);
    check("pin_ld_wb", int'(wb_valid), 1);
    check("pin_ld_n", int'(flag_n), 1);
    check("pin_ld_z", int'(flag_z), 0);

    // Wrap-around INC / DEC on the accumulator
    step(1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_inc_wrap", int'(alu_out), 8'h00);
    check("pin_inc_z", int'(flag_z), 1);
    check("pin_inc_n", int'(flag_n), 0);
    step(1'b0, 1'b1, 3'd4, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_dec_wrap", int'(alu_out), 8'hFF);
    check("pin_dec_n", int'(flag_n), 1);

    // Transfer reg1 -> reg2
    step(1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 8'h42, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 2'd2, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    rd_sel = 2'd2; #1;
    check("pin_xfer_dst", int'(rd_data), 8'h42);
    check("pin_xfer_z", int'(flag_z), 0);
    rd_sel = 2'd1; #1;
    check("pin_xfer_src", int'(rd_data), 8'h42);

    // Rejected ops: illegal code, dst out of range, XFER src out of range
    step(1'b0, 1'b1, 3'd7, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_ill_err", int'(err_op), 1);
    check("pin_ill_wb", int'(wb_valid), 0);
    step(1'b0, 1'b1, 3'd2, 2'd3, 2'd0, 8'h00, 8'h99, 1'b0, 1'b0);
    check("pin_dst3_err", int'(err_op), 1);
    check("pin_dst3_acc", int'(alu_out), 8'hFF);
    step(1'b0, 1'b1, 3'd5, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_src3_err", int'(err_op), 1);
    rd_sel = 2'd3; #1;
    check("pin_rd_oor", int'(rd_data), 0);

    // LD_ALU zero, self-transfer, DEC from zero, CLR, NOP
    step(1'b0, 1'b1, 3'd2, 2'd2, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_self_wb", int'(wb_valid), 1);
    step(1'b0, 1'b1, 3'd4, 2'd2, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    rd_sel = 2'd2; #1;
    check("pin_dec_zero", int'(rd_data), 8'hFF);
    step(1'b0, 1'b1, 3'd6, 2'd1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd0, 2'd2, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_nop_wb", int'(wb_valid), 0);
    check("pin_nop_z", int'(flag_z), 1);
    step(1'b0, 1'b1, 3'd2, 2'd0, 2'd0, 8'h00, 8'h3C, 1'b0, 1'b0);

`ifdef REGBANK_SHADOW_EN
    // Save alongside a load, then restore overriding an INC
    step(1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 8'h11, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 8'h22, 8'h00, 1'b1, 1'b0);
    check("pin_save_op", int'(alu_out), 8'h22);
    step(1'b0, 1'b1, 3'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("pin_restore", int'(alu_out), 8'h11);
    check("pin_restore_wb", int'(wb_valid), 0);
    step(1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 8'h33, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    check("pin_swap", int'(alu_out), 8'h11);
`endif

    // Reset in mid-run overriding a load
    step(1'b1, 1'b1, 3'd1, 2'd1, 2'd0, 8'h77, 8'h00, 1'b0, 1'b0);
    rd_sel = 2'd1; #1;
    check("pin_rst2_reg1", int'(rd_data), 0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("pin_rst2_wb", int'(wb_valid), 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every register and data port.
REQ-002 Parameter NUM_REGS, default 3 (A, X, Y), legal range 1..8, SHALL set the register count; index 0 is the accumulator.
REQ-003 Derived IDXW = max(1, clog2(NUM_REGS)) SHALL size all index ports.
REQ-004 Ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 op_valid  in  1  op request strobe; op_code  in  3  operation; op_dst  in  IDXW  target; op_src  in  IDXW  XFER source.
REQ-007 db_in  in  WIDTH  data-bus operand; alu_in  in  WIDTH  ALU result operand.
REQ-008 rd_sel  in  IDXW  read select; rd_data  out  WIDTH  selected register; alu_out  out  WIDTH  register 0.
REQ-009 wb_valid  out  1  write done; flag_n  out  1; flag_z  out  1; err_op  out  1  rejected-op pulse.
REQ-010 ctx_save  in  1 and ctx_restore  in  1 SHALL exist only when REGBANK_SHADOW_EN is defined.

Function
REQ-011 Op codes: NOP=0, LD_DB=1 (dst<=db_in), LD_ALU=2 (dst<=alu_in), INC=3 (dst<=dst+1), DEC=4 (dst<=dst-1), XFER=5 (dst<=src), CLR=6 (dst<=0), 7 illegal.
REQ-012 An accepted op SHALL write its register at the clock edge where op_valid=1; latency 1 cycle, one op per cycle, no back-pressure.
REQ-013 INC/DEC SHALL wrap modulo 2^WIDTH (all-ones+1=0, 0-1=all-ones).
REQ-014 XFER with op_src==op_dst SHALL rewrite the unchanged value and still update flags.
REQ-015 XFER SHALL read op_src's pre-edge value.
REQ-016 wb_valid SHALL pulse high the cycle after every accepted non-NOP op; NOP SHALL produce no pulse and no flag change.
REQ-017 On write, flag_n SHALL register bit WIDTH-1 of the written value and flag_z SHALL register (value==0); flags SHALL hold otherwise.
REQ-018 op_code=7, op_dst>=NUM_REGS, or XFER with op_src>=NUM_REGS SHALL write nothing, leave flags, and pulse err_op the following cycle.
REQ-019 rd_data and alu_out SHALL be combinational from current register state; rd_sel>=NUM_REGS SHALL return 0.

Reset
REQ-020 reset SHALL clear all registers, flag_n, flag_z, wb_valid, err_op (and shadow copies) to 0 and SHALL override any same-cycle op, save or restore.
REQ-021 An op presented during reset SHALL be discarded and produce no pulse after reset deasserts.

Configuration
REQ-022 Macro REGBANK_SHADOW_EN defined: a shadow copy of all registers plus flags SHALL exist; ctx_save copies current (pre-edge) values to shadow; ctx_restore copies shadow to registers and flags in one edge.
REQ-023 ctx_restore with op_valid in the same cycle: restore SHALL win, op discarded, no wb_valid/err_op pulse; ctx_save with op: shadow captures pre-op values, op proceeds; save and restore together: swap contents.
REQ-024 Macro undefined: no shadow storage, no ctx_* ports, behaviour otherwise identical.

Structure
REQ-025 Package regbank_pkg SHALL hold the op_code enum type (regbank_op_e) and the max-register constant (8).
REQ-026 One sub-module, regbank_nz_flags, SHALL compute and register N/Z from the written value; registers SHALL be a single array in register_bank.

Verification
REQ-027 Reset, then LD_DB dst=1 db_in=0x80 -> next cycle reg1=0x80, wb_valid=1, flag_n=1, flag_z=0.
REQ-028 LD_DB dst=0 0xFF then INC dst=0 -> alu_out=0x00, flag_z=1, flag_n=0; DEC again -> 0xFF, flag_n=1.
REQ-029 reg1=0x42; XFER src=1 dst=2 -> rd_sel=2 gives 0x42, reg1 unchanged, flag_z=0.
REQ-030 op_code=7, then LD_ALU dst=3 with NUM_REGS=3 -> err_op pulses each next cycle, registers and flags unchanged, wb_valid=0.
REQ-031 Shadow on: reg0=0x11, ctx_save with LD_DB dst=0 0x22 same cycle -> reg0=0x22; ctx_restore with INC dst=0 -> reg0=0x11, no wb_valid.
REQ-032 reset asserted same cycle as LD_DB dst=0 0x55 -> reg0=0x00, wb_valid stays 0.
